// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: shares one external combinational 32-bit adder between NREQ
// requesters using round-robin arbitration, with registered operands and a registered result.
module adder_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_cin,
  input  logic [31:0]       add_s,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNTW-1:0]   op_count,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // A producer holds valid and its payload until that edge; ready never depends on a
  // payload, and rsp_* stay stable while rsp_valid is high and rsp_ready is low.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  tag;

  logic            any_valid;
  logic [IDW-1:0]  grant_idx;
  logic            can_grant;
  logic            do_grant;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_cin;
  logic [IDW-1:0]  next_ptr;

  // Circular search: walk offsets from high to low so the offset closest to ptr wins.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int cand;
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid[IDW'(cand)]) begin
        any_valid = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_cin = req_cin[i];
      end
    end
  end

  assign can_grant = rst_n && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign do_grant  = can_grant && any_valid;
  assign req_ready = do_grant ? (NREQ'(1) << grant_idx) : '0;
  assign next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      tag       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_cin <= sel_cin;
            tag     <= grant_idx;
            ptr     <= next_ptr;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_sum   <= add_s;
          rsp_cout  <= add_cout;
          rsp_id    <= tag;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + CNTW'(1);
            rsp_valid <= 1'b0;
            // Accepting the next request here keeps the adder busy every other cycle.
            if (do_grant) begin
              add_a   <= sel_a;
              add_b   <= sel_b;
              add_cin <= sel_cin;
              tag     <= grant_idx;
              ptr     <= next_ptr;
              state   <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: randomized and directed checks of the round-robin adder
// scheduler against a transaction-level reference model with an expected-result queue.
module tb_adder_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;
  localparam int W    = IDW + 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [31:0]        add_a, add_b, add_s;
  logic               add_cin, add_cout;
  logic               rsp_valid, rsp_ready, rsp_cout, busy;
  logic [31:0]        rsp_sum;
  logic [IDW-1:0]     rsp_id;
  logic [CNTW-1:0]    op_count;
  logic [1:0]         dbg_state;
  logic [31:0]        op_a [NREQ];
  logic [31:0]        op_b [NREQ];

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
    end
  end

  // External adder model.
  always_comb {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  adder_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // Small-counter instance so the counter wrap is reachable in a short run.
  logic [1:0]  w_req_valid, w_req_ready, w_req_cin;
  logic [63:0] w_req_a, w_req_b;
  logic [31:0] w_add_a, w_add_b, w_add_s, w_rsp_sum;
  logic        w_add_cin, w_add_cout, w_rsp_valid, w_rsp_ready, w_rsp_cout, w_busy;
  logic [0:0]  w_rsp_id;
  logic [2:0]  w_op_count;
  logic [1:0]  w_dbg_state;

  always_comb {w_add_cout, w_add_s} = {1'b0, w_add_a} + {1'b0, w_add_b} + {32'd0, w_add_cin};

  adder_rr_scheduler #(.NREQ(2), .IDW(1), .CNTW(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_a(w_req_a), .req_b(w_req_b), .req_cin(w_req_cin),
    .add_a(w_add_a), .add_b(w_add_b), .add_cin(w_add_cin), .add_s(w_add_s), .add_cout(w_add_cout),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_sum(w_rsp_sum), .rsp_cout(w_rsp_cout),
    .rsp_id(w_rsp_id), .busy(w_busy), .op_count(w_op_count), .dbg_state(w_dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: transaction phase (0 idle, 1 adding, 2 result offered), rr pointer, count.
  int             m_phase = 0;
  int             m_ptr = 0;
  int             m_cnt = 0;
  logic [W-1:0]   exp_q [$];
  int             act_grants [$];
  logic [NREQ-1:0] gmask = '0;
  logic [NREQ-1:0] refill = '0;

  task automatic sb_sample();
    logic [NREQ-1:0] exp_ready;
    logic [32:0]     s;
    int              g;
    int              j;
    bit              allow;
    bit              found;
    bit              logged;
    if (!rst_n) begin
      m_phase = 0;
      m_ptr = 0;
      m_cnt = 0;
      exp_q.delete();
      gmask = '0;
      return;
    end
    allow = (m_phase == 0) || (m_phase == 2 && rsp_ready);
    found = 1'b0;
    g = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (!found && ((req_valid >> j) & NREQ'(1)) != '0) begin
        found = 1'b1;
        g = j;
      end
    end
    exp_ready = (allow && found) ? (NREQ'(1) << g) : '0;
    checks++;
    if (req_ready !== exp_ready) begin
      failures++;
      $display("FAIL sb_req_ready got=%b exp=%b", req_ready, exp_ready);
    end
    checks++;
    if (rsp_valid !== (m_phase == 2)) begin
      failures++;
      $display("FAIL sb_rsp_valid got=%b exp=%b", rsp_valid, (m_phase == 2));
    end
    checks++;
    if (busy !== (m_phase != 0)) begin
      failures++;
      $display("FAIL sb_busy got=%b exp=%b", busy, (m_phase != 0));
    end
    checks++;
    if (op_count !== CNTW'(m_cnt)) begin
      failures++;
      $display("FAIL sb_op_count got=%0d exp=%0d", op_count, CNTW'(m_cnt));
    end
    if (m_phase == 2 && exp_q.size() > 0) begin
      checks++;
      if ({rsp_id, rsp_cout, rsp_sum} !== exp_q[0]) begin
        failures++;
        $display("FAIL sb_rsp got id=%0d cout=%b sum=%h exp id=%0d cout=%b sum=%h",
                 rsp_id, rsp_cout, rsp_sum, exp_q[0][W-1:33], exp_q[0][32], exp_q[0][31:0]);
      end
    end
    logged = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!logged && ((req_ready >> k) & NREQ'(1)) != '0) begin
        act_grants.push_back(k);
        logged = 1'b1;
      end
    end
    gmask = req_ready;
    if (m_phase == 2 && rsp_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_cnt++;
    end
    if (allow && found) begin
      s = {1'b0, op_a[g]} + {1'b0, op_b[g]} + 33'((req_cin >> g) & NREQ'(1));
      exp_q.push_back({IDW'(g), s});
      m_ptr = (g + 1) % NREQ;
    end
    case (m_phase)
      0: m_phase = (allow && found) ? 1 : 0;
      1: m_phase = 2;
      default: if (rsp_ready) m_phase = found ? 1 : 0;
    endcase
  endtask

  task automatic sample();
    @(negedge clk);
    sb_sample();
  endtask

  // Requester driver: a granted requester either refills with fresh operands or drops valid.
  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (gmask[i]) begin
        if (refill[i]) begin
          op_a[i] = $urandom();
          op_b[i] = $urandom();
          req_cin[i] = 1'($urandom_range(0, 1));
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    gmask = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    refill = '0;
    rsp_ready = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (op_count !== '0) begin failures++; $display("FAIL rst_op_count got=%0d exp=0", op_count); end
    checks++; if ({add_a, add_b, add_cin} !== '0) begin failures++; $display("FAIL rst_add got=%h_%h_%b exp=0", add_a, add_b, add_cin); end
    checks++; if ({rsp_sum, rsp_cout, rsp_id} !== '0) begin failures++; $display("FAIL rst_rsp got=%h_%b_%0d exp=0", rsp_sum, rsp_cout, rsp_id); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    op_a[0] = 32'h0000_0001;
    op_b[0] = 32'hFFFF_FFFF;
    req_cin[0] = 1'b0;
    rsp_ready = 1'b1;
    req_valid[0] = 1'b1;
    sample();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
    advance();
    sample();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t1_exec_valid got=%b exp=0", rsp_valid); end
    checks++; if ({add_a, add_b, add_cin} !== {32'h1, 32'hFFFF_FFFF, 1'b0}) begin
      failures++; $display("FAIL t1_add_ops got=%h_%h_%b exp=00000001_ffffffff_0", add_a, add_b, add_cin); end
    advance();
    sample();
    checks++; if ({rsp_valid, rsp_sum, rsp_cout, rsp_id} !== {1'b1, 32'h0, 1'b1, 2'd0}) begin
      failures++; $display("FAIL t1_rsp got v=%b sum=%h cout=%b id=%0d exp v=1 sum=0 cout=1 id=0",
                           rsp_valid, rsp_sum, rsp_cout, rsp_id); end
    advance();
    sample();
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL t1_op_count got=%0d exp=1", op_count); end
    advance();
  endtask

  task automatic test_all_valid();
    int base;
    apply_reset();
    base = act_grants.size();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom();
      op_b[i] = $urandom();
      req_cin[i] = 1'($urandom_range(0, 1));
    end
    refill = '1;
    req_valid = '1;
    run(20);
    checks++;
    if (act_grants.size() - base != 10) begin
      failures++; $display("FAIL t2_rate got=%0d exp=10", act_grants.size() - base);
    end
    refill = '0;
    run(20);
    checks++;
    if (act_grants.size() - base != 14) begin
      failures++; $display("FAIL t2_total got=%0d exp=14", act_grants.size() - base);
    end
    for (int k = 0; k < 14 && base + k < act_grants.size(); k++) begin
      checks++;
      if (act_grants[base + k] != k % NREQ) begin
        failures++; $display("FAIL t2_order idx=%0d got=%0d exp=%0d", k, act_grants[base + k], k % NREQ);
      end
    end
    checks++;
    if (exp_q.size() != 0 || req_valid !== '0) begin
      failures++; $display("FAIL t2_drain got=%0d pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    op_a[2] = 32'h7FFF_FFFF;
    op_b[2] = 32'h0000_0001;
    req_cin[2] = 1'b1;
    rsp_ready = 1'b0;
    req_valid[2] = 1'b1;
    sample();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL t3_ready2 got=%b exp=0100", req_ready); end
    advance();
    op_a[1] = $urandom();
    op_b[1] = $urandom();
    req_cin[1] = 1'($urandom_range(0, 1));
    req_valid[1] = 1'b1;
    sample();
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL t3_exec_ready got=%b exp=0000", req_ready); end
    advance();
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready} !== {1'b1, 32'h8000_0001, 1'b0, 2'd2, 4'b0000}) begin
        failures++; $display("FAIL t3_hold c=%0d got v=%b sum=%h cout=%b id=%0d rdy=%b exp v=1 sum=80000001 cout=0 id=2 rdy=0000",
                             c, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
      end
      advance();
    end
    rsp_ready = 1'b1;
    sample();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL t3_ready1 got=%b exp=0010", req_ready); end
    advance();
    run(6);
  endtask

  task automatic test_circular();
    apply_reset();
    rsp_ready = 1'b1;
    op_a[1] = $urandom();
    op_b[1] = $urandom();
    req_valid[1] = 1'b1;
    run(4);
    op_a[1] = $urandom();
    op_b[1] = $urandom();
    op_a[3] = $urandom();
    op_b[3] = $urandom();
    req_cin[3] = 1'b1;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    sample();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL t4_first got=%b exp=1000", req_ready); end
    advance();
    sample();
    advance();
    sample();
    checks++; if ({req_ready, rsp_id} !== {4'b0010, 2'd3}) begin
      failures++; $display("FAIL t4_second got rdy=%b id=%0d exp rdy=0010 id=3", req_ready, rsp_id); end
    advance();
    run(6);
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b1;
    op_a[2] = $urandom();
    op_b[2] = $urandom();
    req_valid[2] = 1'b1;
    sample();
    advance();
    #2;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready, dbg_state, add_a} !== '0) begin
      failures++; $display("FAIL t5_async got v=%b busy=%b rdy=%b st=%0d add_a=%h exp all 0",
                           rsp_valid, busy, req_ready, dbg_state, add_a);
    end
    checks++; if (op_count !== '0) begin failures++; $display("FAIL t5_count got=%0d exp=0", op_count); end
    run(1);
    rst_n = 1'b1;
    sample();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL t5_lowest got=%b exp=0010", req_ready); end
    advance();
    run(8);
  endtask

  task automatic test_count_wrap();
    rsp_ready = 1'b1;
    op_a[3] = 32'hFFFF_FFFF;
    op_b[3] = 32'hFFFF_FFFF;
    req_cin[3] = 1'b1;
    req_valid[3] = 1'b1;
    run(2);
    sample();
    checks++;
    if ({rsp_valid, rsp_sum, rsp_cout} !== {1'b1, 32'hFFFF_FFFF, 1'b1}) begin
      failures++; $display("FAIL t6_allones got v=%b sum=%h cout=%b exp v=1 sum=ffffffff cout=1",
                           rsp_valid, rsp_sum, rsp_cout);
    end
    advance();
    run(2);
    apply_reset();
    w_rsp_ready = 1'b1;
    w_req_valid = 2'b01;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (c % 2 == 1) begin
        checks++;
        if (w_op_count !== 3'(((c - 1) / 2) % 8)) begin
          failures++; $display("FAIL t6_wrap c=%0d got=%0d exp=%0d", c, w_op_count, ((c - 1) / 2) % 8);
        end
      end
      advance();
    end
    w_req_valid = 2'b00;
  endtask

  initial begin
    req_valid = '0;
    req_cin = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    w_req_valid = '0;
    w_req_cin = '0;
    w_req_a = {32'h0000_0010, 32'h0000_0003};
    w_req_b = {32'h0000_0020, 32'h0000_0004};
    w_rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_all_valid();
    test_backpressure();
    test_circular();
    test_async_reset();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
